spi_rd_reg: RTL and testbench
=============================

SPI_RD_REG -- requirements
Module: spi_rd_reg

Interface
REQ-001 Parameter ADDR, default 8'h00: register address this block answers.
REQ-002 Parameter BYTES, default 1: value width in bytes; range 1..16.
REQ-003 Parameter PAD, default 8'h00: byte returned after the last value byte has been sent.
REQ-004 clk  input  1: single clock; all state is updated on the rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 addr  input  8: transaction address from the SPI core; valid when first=1.
REQ-007 first  input  1: qualifies strobe as the first byte (address phase) of a transaction.
REQ-008 strobe  input  1: one-cycle pulse per byte slot on the SPI bus.
REQ-009 in_val  input  8*BYTES: live value to read back, sampled at snapshot.
REQ-010 rd_data  output  8: response byte; 8'h00 when inactive, so it can be OR-muxed.
REQ-011 rd_active  output  1: high while this block owns the response bus.
REQ-012 rd_stb  output  1: one-cycle pulse marking that a snapshot was taken; used by clear-on-read sources.

Function
REQ-013 Hit: strobe=1, first=1 and addr==ADDR in the same cycle.
REQ-014 Hit at cycle n: at n+1 snap=in_val(sampled at n), rd_active=1, rd_data=snap[8*BYTES-1 -: 8] (MSB byte), byte index=1, rd_stb=1.
REQ-015 rd_stb: high exactly one cycle per hit; low otherwise.
REQ-016 FSM states: IDLE and ACTIVE. IDLE->ACTIVE on hit; ACTIVE->IDLE on strobe with first=1 and addr!=ADDR; ACTIVE->ACTIVE (restart) on hit.
REQ-017 In ACTIVE, strobe with first=0 at cycle m: at m+1 rd_data = next lower byte of snap and index increments.
REQ-018 After index reaches BYTES, each further first=0 strobe gives rd_data=PAD; the index saturates at BYTES and does not wrap.
REQ-019 addr is ignored when first=0.
REQ-020 In IDLE, strobes with first=0 are ignored; rd_data and rd_active stay 0.
REQ-021 ACTIVE->IDLE: at the next cycle rd_active=0 and rd_data=8'h00.
REQ-022 Hit while ACTIVE: takes a fresh snapshot, resets the index and outputs the new MSB byte, exactly as REQ-014.
REQ-023 Without a strobe, rd_data, rd_active and snap hold their values; changes on in_val have no effect until the next hit.
REQ-024 BYTES=1: the hit outputs the single byte; every later first=0 strobe gives PAD.
REQ-025 The index counter is clog2(BYTES+1) bits wide.
REQ-026 All outputs are registered, with no combinational path from the inputs.

Reset
REQ-027 While rst=1: state IDLE, snap=0, index=0, rd_data=8'h00, rd_active=0, rd_stb=0.
REQ-028 Reset asserted mid-transaction: the transaction is abandoned immediately, asynchronously.
REQ-029 After rst deasserts: the first=0 strobes of the interrupted transaction are ignored until the next hit.

Verification (ADDR=8'h10, BYTES=3, PAD=8'h00 unless noted)
REQ-030 Basic read: in_val=24'hA1B2C3; hit; then 3 first=0 strobes.
- Response: rd_data A1, B2, C3, 00, each one cycle after its strobe.
- rd_stb pulses once, one cycle after the hit.
REQ-031 Snapshot: hit, then in_val changes to 24'h112233 before the next strobes.
- Response: remaining bytes are still B2, C3.
REQ-032 Miss: strobe with first=1, addr=8'h11.
- Response: rd_active=0, rd_data=00, rd_stb=0.
- Following first=0 strobes are ignored.
REQ-033 Restart: hit, one data strobe (B2), then a hit with in_val=24'h445566.
- Response: rd_data=44, rd_stb pulses again, and the next strobe gives 55.
REQ-034 Reset mid-read: assert rst after byte A1, release it, then issue a first=0 strobe.
- Response: outputs are 0 immediately on rst and remain 0 after the strobe.
REQ-035 BYTES=1, PAD=8'hFF, in_val=8'h5A: hit, then 2 first=0 strobes.
- Response: rd_data 5A, FF, FF.

Source files
------------

// File: rtl/spi_rd_reg.sv
// spi_rd_reg: read-only SPI register slice.
// On an address hit it snapshots in_val and streams it out MSB byte first,
// one byte per strobe, then returns PAD. rd_data is 0 whenever the block is
// not driving the response bus, so several instances can be OR-muxed.
module spi_rd_reg #(
    parameter logic [7:0] ADDR  = 8'h00,
    parameter int         BYTES = 1,
    parameter logic [7:0] PAD   = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         addr,
    input  logic               first,
    input  logic               strobe,
    input  logic [8*BYTES-1:0] in_val,
    output logic [7:0]         rd_data,
    output logic               rd_active,
    output logic               rd_stb
);

    localparam int IW = $clog2(BYTES + 1);
    localparam int NSEL = 2 ** IW;
    localparam logic [IW-1:0] LAST = IW'(BYTES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [8*BYTES-1:0] snap_reg, snap_next;
    logic [IW-1:0]      idx_reg, idx_next;
    logic [7:0]         rd_data_reg, rd_data_next;
    logic               rd_active_reg, rd_active_next;
    logic               rd_stb_reg, rd_stb_next;

    logic               hit;
    logic               leave;

    // Byte selector indexed by the byte counter: entry k is the k-th byte of
    // the snapshot counted from the MSB end; every entry past the last value
    // byte reads PAD, which gives the saturating PAD behaviour for free.
    logic [7:0] sel_bytes [NSEL];

    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_sel
            if (gi < BYTES) begin : g_val
                assign sel_bytes[gi] = snap_reg[8*(BYTES-gi)-1 -: 8];
            end else begin : g_pad
                assign sel_bytes[gi] = PAD;
            end
        end
    endgenerate

    assign hit   = strobe && first && (addr == ADDR);
    assign leave = strobe && first && (addr != ADDR);

    // State and datapath registers; reset abandons any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            snap_reg      <= '0;
            idx_reg       <= '0;
            rd_data_reg   <= 8'h00;
            rd_active_reg <= 1'b0;
            rd_stb_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            snap_reg      <= snap_next;
            idx_reg       <= idx_next;
            rd_data_reg   <= rd_data_next;
            rd_active_reg <= rd_active_next;
            rd_stb_reg    <= rd_stb_next;
        end
    end

    // Next-state and output logic; everything holds unless a strobe arrives.
    always_comb begin
        state_next     = state_reg;
        snap_next      = snap_reg;
        idx_next       = idx_reg;
        rd_data_next   = rd_data_reg;
        rd_active_next = rd_active_reg;
        rd_stb_next    = 1'b0;

        if (hit) begin
            // Fresh snapshot from IDLE or a restart from ACTIVE look the same.
            state_next     = ACTIVE;
            snap_next      = in_val;
            idx_next       = IW'(1);
            rd_data_next   = in_val[8*BYTES-1 -: 8];
            rd_active_next = 1'b1;
            rd_stb_next    = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Data strobes and foreign addresses are not ours.
                end
                ACTIVE: begin
                    if (leave) begin
                        state_next     = IDLE;
                        idx_next       = '0;
                        rd_data_next   = 8'h00;
                        rd_active_next = 1'b0;
                    end else if (strobe) begin
                        rd_data_next = sel_bytes[idx_reg];
                        if (idx_reg != LAST) begin
                            idx_next = idx_reg + IW'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign rd_data   = rd_data_reg;
    assign rd_active = rd_active_reg;
    assign rd_stb    = rd_stb_reg;

endmodule

// File: tb/tb_spi_rd_reg.sv
// tb_spi_rd_reg: directed bench for spi_rd_reg. A 3-byte instance carries
// most scenarios; a 1-byte instance with PAD=FF shares the bus inputs.
module tb_spi_rd_reg;

    logic        clk;
    logic        rst;
    logic [7:0]  addr;
    logic        first;
    logic        strobe;
    logic [23:0] in_val;
    logic [7:0]  in_val1;
    logic [7:0]  rd_data,  rd_data1;
    logic        rd_active, rd_active1;
    logic        rd_stb,   rd_stb1;

    int tests;
    int fails;

    spi_rd_reg #(.ADDR(8'h10), .BYTES(3), .PAD(8'h00)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .first     (first),
        .strobe    (strobe),
        .in_val    (in_val),
        .rd_data   (rd_data),
        .rd_active (rd_active),
        .rd_stb    (rd_stb)
    );

    spi_rd_reg #(.ADDR(8'h10), .BYTES(1), .PAD(8'hFF)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .first     (first),
        .strobe    (strobe),
        .in_val    (in_val1),
        .rd_data   (rd_data1),
        .rd_active (rd_active1),
        .rd_stb    (rd_stb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One strobe slot: drive on a falling edge, the DUT registers on the
    // rising edge, and outputs are stable by the next falling edge.
    task automatic do_strobe(input logic f, input logic [7:0] a);
        @(negedge clk);
        first  = f;
        addr   = a;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        first  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycle();
        idle_cycle();
        tests++;
        if ({rd_active, rd_stb, rd_data} !== 10'h000) begin
            fails++;
            $display("[TB] FAIL reset_main got act=%b stb=%b data=%h want 0 0 00", rd_active, rd_stb, rd_data);
        end else $display("[TB] reset_main ok");
        tests++;
        if ({rd_active1, rd_stb1, rd_data1} !== 10'h000) begin
            fails++;
            $display("[TB] FAIL reset_b1 got act=%b stb=%b data=%h want 0 0 00", rd_active1, rd_stb1, rd_data1);
        end else $display("[TB] reset_b1 ok");
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [5];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
        exp_b[3] = 8'h00; exp_b[4] = 8'h00;
        in_val = 24'hA1B2C3;
        do_strobe(1'b1, 8'h10);
        tests++;
        if ({rd_active, rd_stb, rd_data} !== {1'b1, 1'b1, 8'hA1}) begin
            fails++;
            $display("[TB] FAIL basic_hit got act=%b stb=%b data=%h want 1 1 a1", rd_active, rd_stb, rd_data);
        end else $display("[TB] basic_hit ok");
        for (int i = 1; i < 5; i++) begin
            do_strobe(1'b0, 8'h00);
            tests++;
            if ({rd_active, rd_stb, rd_data} !== {1'b1, 1'b0, exp_b[i]}) begin
                fails++;
                $display("[TB] FAIL basic_byte%0d got act=%b stb=%b data=%h want 1 0 %h", i, rd_active, rd_stb, rd_data, exp_b[i]);
            end else $display("[TB] basic_byte%0d ok data=%h", i, rd_data);
        end
        do_strobe(1'b1, 8'h11);
        tests++;
        if ({rd_active, rd_stb, rd_data} !== 10'h000) begin
            fails++;
            $display("[TB] FAIL basic_leave got act=%b stb=%b data=%h want 0 0 00", rd_active, rd_stb, rd_data);
        end else $display("[TB] basic_leave ok");
    endtask

    task automatic test_snapshot();
        in_val = 24'hA1B2C3;
        do_strobe(1'b1, 8'h10);
        in_val = 24'h112233;
        idle_cycle();
        idle_cycle();
        tests++;
        if ({rd_active, rd_stb, rd_data} !== {1'b1, 1'b0, 8'hA1}) begin
            fails++;
            $display("[TB] FAIL snap_hold got act=%b stb=%b data=%h want 1 0 a1", rd_active, rd_stb, rd_data);
        end else $display("[TB] snap_hold ok");
        do_strobe(1'b0, 8'h00);
        tests++;
        if (rd_data !== 8'hB2) begin
            fails++;
            $display("[TB] FAIL snap_byte1 got %h want b2", rd_data);
        end else $display("[TB] snap_byte1 ok");
        do_strobe(1'b0, 8'h00);
        tests++;
        if (rd_data !== 8'hC3) begin
            fails++;
            $display("[TB] FAIL snap_byte2 got %h want c3", rd_data);
        end else $display("[TB] snap_byte2 ok");
        do_strobe(1'b1, 8'h22);
    endtask

    task automatic test_miss();
        in_val = 24'hA1B2C3;
        do_strobe(1'b1, 8'h11);
        tests++;
        if ({rd_active, rd_stb, rd_data} !== 10'h000) begin
            fails++;
            $display("[TB] FAIL miss_addr got act=%b stb=%b data=%h want 0 0 00", rd_active, rd_stb, rd_data);
        end else $display("[TB] miss_addr ok");
        do_strobe(1'b0, 8'h10);
        tests++;
        if ({rd_active, rd_stb, rd_data} !== 10'h000) begin
            fails++;
            $display("[TB] FAIL miss_data got act=%b stb=%b data=%h want 0 0 00", rd_active, rd_stb, rd_data);
        end else $display("[TB] miss_data ok");
    endtask

    task automatic test_restart();
        in_val = 24'hA1B2C3;
        do_strobe(1'b1, 8'h10);
        do_strobe(1'b0, 8'h00);
        tests++;
        if (rd_data !== 8'hB2) begin
            fails++;
            $display("[TB] FAIL restart_pre got %h want b2", rd_data);
        end else $display("[TB] restart_pre ok");
        in_val = 24'h445566;
        do_strobe(1'b1, 8'h10);
        tests++;
        if ({rd_active, rd_stb, rd_data} !== {1'b1, 1'b1, 8'h44}) begin
            fails++;
            $display("[TB] FAIL restart_hit got act=%b stb=%b data=%h want 1 1 44", rd_active, rd_stb, rd_data);
        end else $display("[TB] restart_hit ok");
        do_strobe(1'b0, 8'h00);
        tests++;
        if ({rd_active, rd_stb, rd_data} !== {1'b1, 1'b0, 8'h55}) begin
            fails++;
            $display("[TB] FAIL restart_next got act=%b stb=%b data=%h want 1 0 55", rd_active, rd_stb, rd_data);
        end else $display("[TB] restart_next ok");
        do_strobe(1'b1, 8'h11);
    endtask

    task automatic test_reset_mid();
        in_val = 24'hA1B2C3;
        do_strobe(1'b1, 8'h10);
        tests++;
        if (rd_data !== 8'hA1) begin
            fails++;
            $display("[TB] FAIL rstmid_pre got %h want a1", rd_data);
        end else $display("[TB] rstmid_pre ok");
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({rd_active, rd_stb, rd_data} !== 10'h000) begin
            fails++;
            $display("[TB] FAIL rstmid_async got act=%b stb=%b data=%h want 0 0 00", rd_active, rd_stb, rd_data);
        end else $display("[TB] rstmid_async ok");
        @(negedge clk);
        rst = 1'b0;
        do_strobe(1'b0, 8'h00);
        tests++;
        if ({rd_active, rd_stb, rd_data} !== 10'h000) begin
            fails++;
            $display("[TB] FAIL rstmid_after got act=%b stb=%b data=%h want 0 0 00", rd_active, rd_stb, rd_data);
        end else $display("[TB] rstmid_after ok");
    endtask

    task automatic test_bytes1();
        in_val1 = 8'h5A;
        do_strobe(1'b1, 8'h10);
        tests++;
        if ({rd_active1, rd_stb1, rd_data1} !== {1'b1, 1'b1, 8'h5A}) begin
            fails++;
            $display("[TB] FAIL b1_hit got act=%b stb=%b data=%h want 1 1 5a", rd_active1, rd_stb1, rd_data1);
        end else $display("[TB] b1_hit ok");
        for (int i = 1; i <= 2; i++) begin
            do_strobe(1'b0, 8'h00);
            tests++;
            if ({rd_active1, rd_stb1, rd_data1} !== {1'b1, 1'b0, 8'hFF}) begin
                fails++;
                $display("[TB] FAIL b1_pad%0d got act=%b stb=%b data=%h want 1 0 ff", i, rd_active1, rd_stb1, rd_data1);
            end else $display("[TB] b1_pad%0d ok", i);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        addr    = 8'h00;
        first   = 1'b0;
        strobe  = 1'b0;
        in_val  = 24'h000000;
        in_val1 = 8'h00;
        test_reset();
        test_basic();
        test_snapshot();
        test_miss();
        test_restart();
        test_reset_mid();
        test_bytes1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
